// File: rtl/spike_line_packer_v2_pkg.sv
// Shared defaults for the spike line packer: spike width, line size, kernel,
// the derived slot-pointer width and the runtime line-length calculation.
package spike_line_packer_v2_pkg;

  localparam int DEF_TIME_STEPS = 4;
  localparam int DEF_IMG_WIDTH  = 32;
  localparam int DEF_LANES      = 2;
  localparam int DEF_KERNEL     = 3;
  localparam int DEF_PTR_W      = $clog2(DEF_IMG_WIDTH + 1);

  // Valid conv output width, computed at 16 bits and clamped to the buffer size.
  function automatic logic [15:0] calc_line_len(input logic [15:0] img_size,
                                                input int          kernel,
                                                input int          width);
    logic [15:0] len;
    len = img_size - 16'(kernel) + 16'd1;
    return (len > 16'(width)) ? 16'(width) : len;
  endfunction

endpackage

// File: rtl/spike_line_packer_v2_buf.sv
// One line buffer: lane writes at the fill pointer, whole-line clear on the
// first beat of a line, and a full flag held until the line is taken.
module spike_line_packer_v2_buf #(
  parameter int TIME_STEPS = 4,
  parameter int IMG_WIDTH  = 32,
  parameter int LANES      = 2,
  parameter int PTR_W      = 6
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            wr_en,
  input  logic                            first,
  input  logic                            set_full,
  input  logic                            clr_full,
  input  logic [PTR_W-1:0]                wr_ptr,
  input  logic [PTR_W-1:0]                line_len,
  input  logic [LANES*TIME_STEPS-1:0]     lanes,
  output logic [IMG_WIDTH*TIME_STEPS-1:0] data,
  output logic                            full
);

  logic [IMG_WIDTH*TIME_STEPS-1:0] data_nxt;

  // Lanes landing at or beyond line_len are dropped, so unused slots stay zero.
  always_comb begin
    data_nxt = first ? '0 : data;
    for (int j = 0; j < LANES; j++) begin
      if (int'(wr_ptr) + j < int'(line_len))
        data_nxt[(int'(wr_ptr) + j)*TIME_STEPS +: TIME_STEPS] = lanes[j*TIME_STEPS +: TIME_STEPS];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      full <= 1'b0;
    end else begin
      if (wr_en)
        data <= data_nxt;
      if (set_full)
        full <= 1'b1;
      else if (clr_full)
        full <= 1'b0;
    end
  end

endmodule

// File: rtl/spike_line_packer_v2.sv
// Packs multi-lane pixel spike beats into ping-pong line buffers and hands
// completed lines downstream with line/frame indexing.
module spike_line_packer_v2
  import spike_line_packer_v2_pkg::*;
#(
  parameter int TIME_STEPS = DEF_TIME_STEPS,
  parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
  parameter int LANES      = DEF_LANES,
  parameter int KERNEL     = DEF_KERNEL
) (
  input  logic                            s_clk,
  input  logic                            s_rst_n,
  input  logic                            code_valid,
  input  logic [15:0]                     conv_img_size,
  input  logic [15:0]                     conv_line_num,
  input  logic [LANES*TIME_STEPS-1:0]     i_spikes_in,
  input  logic                            i_spikes_valid,
  output logic                            o_spikes_ready,
  output logic [IMG_WIDTH*TIME_STEPS-1:0] o_line_data,
  output logic                            o_line_valid,
  input  logic                            i_line_ready,
  output logic                            o_line_last,
  output logic [15:0]                     o_line_idx,
  output logic                            o_busy
);

  localparam int PTR_W = $clog2(IMG_WIDTH + 1);
  localparam int DW    = IMG_WIDTH * TIME_STEPS;

  logic             cfg_ok;
  logic [PTR_W-1:0] line_len;
  logic [15:0]      line_num;
  logic [PTR_W-1:0] wr_ptr;
  logic             fill_sel;
  logic             rd_sel;
  logic [15:0]      line_idx;

  logic [1:0]       buf_full;
  logic [DW-1:0]    buf_data [2];

  logic             cfg_good;
  logic [PTR_W-1:0] len_clamped;
  logic [PTR_W:0]   wr_end;
  logic             accept;
  logic             complete;
  logic             release_line;

  assign cfg_good    = (conv_img_size >= 16'(KERNEL)) && (conv_line_num != 16'd0);
  assign len_clamped = PTR_W'(calc_line_len(conv_img_size, KERNEL, IMG_WIDTH));

  assign o_spikes_ready = cfg_ok && !buf_full[fill_sel];
  assign o_line_valid   = buf_full[rd_sel];
  assign o_line_data    = rd_sel ? buf_data[1] : buf_data[0];
  assign o_line_idx     = line_idx;
  assign o_line_last    = (line_idx == line_num - 16'd1);
  assign o_busy         = (|buf_full) || (wr_ptr != '0);

  // One bit of headroom so wr_ptr+LANES cannot wrap before the compare.
  assign wr_end       = {1'b0, wr_ptr} + (PTR_W+1)'(LANES);
  assign accept       = i_spikes_valid && o_spikes_ready;
  assign complete     = accept && (wr_end >= {1'b0, line_len});
  assign release_line = o_line_valid && i_line_ready;

  for (genvar b = 0; b < 2; b++) begin : g_buf
    spike_line_packer_v2_buf #(
      .TIME_STEPS (TIME_STEPS),
      .IMG_WIDTH  (IMG_WIDTH),
      .LANES      (LANES),
      .PTR_W      (PTR_W)
    ) u_buf (
      .clk      (s_clk),
      .rst_n    (s_rst_n),
      .wr_en    (accept && (fill_sel == 1'(b))),
      .first    (wr_ptr == '0),
      .set_full (complete && (fill_sel == 1'(b))),
      .clr_full (release_line && (rd_sel == 1'(b))),
      .wr_ptr   (wr_ptr),
      .line_len (line_len),
      .lanes    (i_spikes_in),
      .data     (buf_data[b]),
      .full     (buf_full[b])
    );
  end

  // Config is only taken while idle, so a new layer never splits a line or frame.
  always_ff @(posedge s_clk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      cfg_ok   <= 1'b0;
      line_len <= '0;
      line_num <= '0;
      wr_ptr   <= '0;
      fill_sel <= 1'b0;
      rd_sel   <= 1'b0;
      line_idx <= '0;
    end else begin
      if (code_valid && !o_busy) begin
        cfg_ok   <= cfg_good;
        line_len <= len_clamped;
        line_num <= conv_line_num;
        line_idx <= '0;
      end
      if (accept) begin
        if (complete) begin
          wr_ptr   <= '0;
          fill_sel <= ~fill_sel;
        end else begin
          wr_ptr   <= wr_end[PTR_W-1:0];
        end
      end
      if (release_line) begin
        rd_sel   <= ~rd_sel;
        line_idx <= o_line_last ? 16'd0 : line_idx + 16'd1;
      end
    end
  end

endmodule

// File: doc/spike_line_packer_v2.md
Name: spike_line_packer_v2

Overview:
Parametrised successor of the spike line organiser. Collects per-pixel spike vectors (TIME_STEPS bits each, LANES pixels per beat) into a line word of IMG_WIDTH slots and presents each completed line to the Tmp-BRAM writer. Uses a ping-pong pair of line buffers with valid/ready on both sides, so input continues while a finished line waits downstream. Adds line/frame indexing, runtime line length with clamping, and zero-fill of unused slots.

Parameters:
TIME_STEPS, 4, spike bits per pixel
IMG_WIDTH, 32, line buffer slots (max pixels per line)
LANES, 2, pixels accepted per input beat (1..IMG_WIDTH)
KERNEL, 3, conv kernel size; line_len = conv_img_size - KERNEL + 1

Ports:
s_clk  in  1  clock
s_rst_n  in  1  asynchronous active-low reset
code_valid  in  1  config strobe
conv_img_size  in  16  input image width for this layer
conv_line_num  in  16  lines per frame
i_spikes_in  in  LANES*TIME_STEPS  pixel spike vectors, lane 0 in LSBs
i_spikes_valid  in  1  input beat valid
o_spikes_ready  out  1  input beat accepted when valid&&ready
o_line_data  out  IMG_WIDTH*TIME_STEPS  completed line, slot k at bits [(k+1)*TIME_STEPS-1 : k*TIME_STEPS]
o_line_valid  out  1  line available
i_line_ready  in  1  downstream accepts line
o_line_last  out  1  presented line is last of frame
o_line_idx  out  16  index of presented line
o_busy  out  1  any buffer non-empty or fill in progress

Behaviour:
- Reset: s_rst_n low clears both buffers, pointers, counters and config asynchronously. All outputs reset to 0; o_spikes_ready=0 while unconfigured. Reset mid-line discards partial and pending lines.
- Config: latched on code_valid only when o_busy=0; ignored otherwise. line_len = conv_img_size-KERNEL+1, clamped to IMG_WIDTH. If conv_img_size<KERNEL or conv_line_num=0, block is unconfigured and ready stays 0.
- Fill: wr_ptr starts at 0. Accepted beat writes lane j to slot wr_ptr+j if that slot < line_len; lanes beyond are dropped. First beat of a line clears all other slots of the fill buffer, so slots >= line_len read 0. wr_ptr += LANES.
- Line complete when wr_ptr+LANES >= line_len on an accepted beat. Buffer is marked full, wr_ptr->0, fill selects the other buffer. A partial final beat is legal.
- o_spikes_ready = configured && fill buffer not full. With both buffers full, ready=0.
- Output: o_line_valid=1 while read buffer is full; o_line_data, o_line_last and o_line_idx are stable until valid&&i_line_ready. On handshake, the buffer is freed and the read select toggles. A second full buffer is presented the next cycle (no bubble).
- Latency: completing beat at edge N -> o_line_valid high after edge N (visible cycle N+1); no combinational input->output paths.
- Simultaneous completion of one buffer and release of the other in the same cycle is legal; both take effect and ready stays 1.
- o_line_idx counts presented lines 0..conv_line_num-1 and advances on output handshake. o_line_last = (idx == conv_line_num-1); idx wraps to 0 after last.
- Widths: slot pointers use $clog2(IMG_WIDTH+1) bits; line_len arithmetic is done at 16 bits before clamping.

Decomposition:
- Shared hyper_para package holds TIME_STEPS, IMG_WIDTH, KERNEL and the derived pointer width.
- One natural sub-module: spike_line_buf (single line buffer with slot write, clear-on-first-beat and full flag), instantiated twice.
- Ping-pong select, handshakes and counters live in the top level.

Test Plan:
- conv_img_size=10, LANES=2, 4 beats with lanes (1,2),(3,4),(5,6),(7,8), i_line_ready=1 -> one o_line_valid pulse the cycle after beat 4; slots 0..7 = 1..8, slots 8..31 = 0.
- conv_img_size=9 (line_len 7), beats (1,2),(3,4),(5,6),(7,F) -> slot 6=7, lane value F dropped, slot 7=0, line completes on beat 4.
- i_line_ready=0, stream 3 lines -> two lines buffered; o_spikes_ready drops after line 2 completes; line 1 data held stable. Raising ready yields lines 1 then 2 on back-to-back cycles, then input resumes.
- conv_line_num=3, stream 4 lines -> o_line_idx 0,1,2,0; o_line_last high only with idx 2.
- conv_img_size=40 -> line_len clamped to 32 (16 beats). code_valid with conv_img_size=12 while o_busy=1 -> ignored.
- Assert s_rst_n low after 2 beats of a line with one line pending -> outputs 0 asynchronously; after reconfig, next line starts at slot 0 with no stale data.
